// File: rtl/postprocess_reg.sv
// postprocess_reg: result-side output stage of the 4-bit ALU datapath.
// Captures the adder sum together with Z/N/C/V flags derived from the
// operands that fed the adder, and buffers up to two results in a small
// queue with valid/ready handshakes on both the producer and consumer side.
// A sticky overflow bit records any accepted result that overflowed.

module postprocess_reg #(
   parameter int W     = 4,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   output logic         InReady,
   output logic         OutValid,
   output logic [W-1:0] Result,
   output logic [3:0]   Flags,
   output logic         StickyV,
   input  logic         InValid,
   input  logic [W-1:0] Sum,
   input  logic         Cout,
   input  logic [W-1:0] AMod,
   input  logic [W-1:0] BMod,
   input  logic [2:0]   Op,
   input  logic         OutReady,
   input  logic         ClrSticky
);

   // One stored entry is the sum with its flags packed below it.
   localparam int EW = W + 4;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_TWO   = 2'b10
   } state_t;

   // Flag rule for one adder result: {Z, N, C, V}.
   // Subtraction reports borrow, so the carry sense is inverted for Op=001.
   function automatic logic [3:0] calc_flags(
      input logic [W-1:0] sum_i,
      input logic         cout_i,
      input logic [W-1:0] a_i,
      input logic [W-1:0] b_i,
      input logic [2:0]   op_i
   );
      logic z_v;
      logic n_v;
      logic c_v;
      logic v_v;
      z_v = (sum_i == {W{1'b0}});
      n_v = sum_i[W-1];
      c_v = (op_i == 3'b001) ? ~cout_i : cout_i;
      v_v = (a_i[W-1] == b_i[W-1]) & (sum_i[W-1] != a_i[W-1]);
      return {z_v, n_v, c_v, v_v};
   endfunction

   state_t          state_q;
   state_t          state_d;
   logic [EW-1:0]   slot_q [DEPTH];
   logic [EW-1:0]   slot_d [DEPTH];
   logic            sticky_q;
   logic            sticky_d;

   logic            out_valid_s;
   logic            in_ready_s;
   logic            accept_s;
   logic            pop_s;
   logic [3:0]      in_flags_s;
   logic [EW-1:0]   in_entry_s;

   // Handshake decode and the entry the producer is offering this cycle.
   always_comb begin
      accept_s   = InValid & in_ready_s;
      pop_s      = out_valid_s & OutReady;
      in_flags_s = calc_flags(Sum, Cout, AMod, BMod, Op);
      in_entry_s = {Sum, in_flags_s};
   end

   // State register: the registered entry count.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; accept and pop together in ONE keeps the count at one.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept_s) begin
               state_d = ST_ONE;
            end else begin
               state_d = ST_EMPTY;
            end
         end
         ST_ONE: begin
            if (accept_s && !pop_s) begin
               state_d = ST_TWO;
            end else if (pop_s && !accept_s) begin
               state_d = ST_EMPTY;
            end else begin
               state_d = ST_ONE;
            end
         end
         ST_TWO: begin
            if (pop_s) begin
               state_d = ST_ONE;
            end else begin
               state_d = ST_TWO;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
   end

   // Output decode: handshake signals come straight from the registered state.
   always_comb begin
      out_valid_s = 1'b0;
      in_ready_s  = 1'b1;
      case (state_q)
         ST_EMPTY: begin
            out_valid_s = 1'b0;
            in_ready_s  = 1'b1;
         end
         ST_ONE: begin
            out_valid_s = 1'b1;
            in_ready_s  = 1'b1;
         end
         ST_TWO: begin
            out_valid_s = 1'b1;
            in_ready_s  = 1'b0;
         end
         default: begin
            out_valid_s = 1'b0;
            in_ready_s  = 1'b1;
         end
      endcase
   end

   // Queue storage update: slot 0 is always the head presented downstream,
   // slot 1 holds the second entry. The head is left untouched on a plain pop
   // so the last popped value remains visible while empty.
   always_comb begin
      slot_d[0] = slot_q[0];
      slot_d[1] = slot_q[1];
      case (state_q)
         ST_EMPTY: begin
            if (accept_s) begin
               slot_d[0] = in_entry_s;
            end else begin
               slot_d[0] = slot_q[0];
            end
         end
         ST_ONE: begin
            if (accept_s && pop_s) begin
               slot_d[0] = in_entry_s;
            end else if (accept_s) begin
               slot_d[1] = in_entry_s;
            end else begin
               slot_d[0] = slot_q[0];
            end
         end
         ST_TWO: begin
            if (pop_s) begin
               slot_d[0] = slot_q[1];
            end else begin
               slot_d[0] = slot_q[0];
            end
         end
         default: begin
            slot_d[0] = slot_q[0];
            slot_d[1] = slot_q[1];
         end
      endcase
   end

   // Sticky overflow: an overflowing accept takes priority over a clear.
   always_comb begin
      if (accept_s && in_flags_s[0]) begin
         sticky_d = 1'b1;
      end else if (ClrSticky) begin
         sticky_d = 1'b0;
      end else begin
         sticky_d = sticky_q;
      end
   end

   // Data registers: queue slots and sticky flag, all cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q[0] <= {EW{1'b0}};
         slot_q[1] <= {EW{1'b0}};
         sticky_q  <= 1'b0;
      end else begin
         slot_q[0] <= slot_d[0];
         slot_q[1] <= slot_d[1];
         sticky_q  <= sticky_d;
      end
   end

   assign OutValid = out_valid_s;
   assign InReady  = in_ready_s;
   assign Result   = slot_q[0][EW-1:4];
   assign Flags    = slot_q[0][3:0];
   assign StickyV  = sticky_q;

   postprocess_reg_chk #(
      .W (W)
   ) u_chk (
      .clk      (clk),
      .reset    (reset),
      .InReady  (InReady),
      .OutValid (OutValid),
      .OutReady (OutReady),
      .Result   (Result),
      .Flags    (Flags)
   );

endmodule

// Protocol properties of the output stage.
module postprocess_reg_chk #(
   parameter int W = 4
) (
   input logic         clk,
   input logic         reset,
   input logic         InReady,
   input logic         OutValid,
   input logic         OutReady,
   input logic [W-1:0] Result,
   input logic [3:0]   Flags
);

   // The queue can never be both full and empty.
   a_not_stuck: assert property (@(posedge clk) disable iff (reset)
      (InReady || OutValid));

   // A reset always leaves the queue empty and ready.
   a_reset_empty: assert property (@(posedge clk)
      reset |=> (!OutValid && InReady));

   // A stalled head keeps its data.
   a_head_stable: assert property (@(posedge clk)
      $past(OutValid && !OutReady && !reset) |-> ($stable(Result) && $stable(Flags)));

endmodule

// File: tb/tb_postprocess_reg.sv
// Scoreboard bench for postprocess_reg: the driver pushes a hand-computed
// {Result, Flags} expectation whenever an entry is accepted, and a separate
// monitor pops and compares whenever the DUT hands an entry to the consumer.

module tb_postprocess_reg;

   logic       clk;
   logic       reset;
   logic       InReady;
   logic       OutValid;
   logic [3:0] Result;
   logic [3:0] Flags;
   logic       StickyV;
   logic       InValid;
   logic [3:0] Sum;
   logic       Cout;
   logic [3:0] AMod;
   logic [3:0] BMod;
   logic [2:0] Op;
   logic       OutReady;
   logic       ClrSticky;

   int         chk_cnt  = 0;
   int         pass_cnt = 0;
   logic [7:0] sb [$];

   postprocess_reg #(.W(4), .DEPTH(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .InReady   (InReady),
      .OutValid  (OutValid),
      .Result    (Result),
      .Flags     (Flags),
      .StickyV   (StickyV),
      .InValid   (InValid),
      .Sum       (Sum),
      .Cout      (Cout),
      .AMod      (AMod),
      .BMod      (BMod),
      .Op        (Op),
      .OutReady  (OutReady),
      .ClrSticky (ClrSticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Offer one entry until accepted; push its expected {sum, flags} on acceptance.
   task automatic send(input logic [3:0] s, input logic c, input logic [3:0] a,
                       input logic [3:0] b, input logic [2:0] op, input logic [3:0] ef);
      bit done;
      done = 1'b0;
      InValid = 1'b1; Sum = s; Cout = c; AMod = a; BMod = b; Op = op;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (InReady && !reset) begin
            sb.push_back({s, ef});
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      InValid = 1'b0;
      if (!done) check("send_timeout", 32'd0, 32'd1);
   endtask

   // Monitor: compare every entry the consumer takes against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && OutValid && OutReady) begin
            if (sb.size() == 0) begin
               check("unexpected_pop", {24'd0, Result, Flags}, 32'hFFFF);
            end else begin
               logic [7:0] e;
               e = sb.pop_front();
               check("pop_data", {24'd0, Result, Flags}, {24'd0, e});
            end
         end
      end
   end

   initial begin
      reset = 1'b1; InValid = 1'b0; Sum = 4'd0; Cout = 1'b0; AMod = 4'd0;
      BMod = 4'd0; Op = 3'd0; OutReady = 1'b0; ClrSticky = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;

      // Idle after reset
      check("rst_outvalid", OutValid, 1'b0);
      check("rst_inready",  InReady,  1'b1);
      check("rst_result",   Result,   4'b0000);
      check("rst_flags",    Flags,    4'b0000);
      check("rst_sticky",   StickyV,  1'b0);

      // Signed overflow add, then a zero-result subtract (no borrow)
      OutReady = 1'b1;
      send(4'b1000, 1'b0, 4'b0111, 4'b0001, 3'b000, 4'b0101);
      check("add_sticky",   StickyV,  1'b1);
      check("add_outvalid", OutValid, 1'b1);
      send(4'b0000, 1'b1, 4'b0011, 4'b1100, 3'b001, 4'b1000);
      @(posedge clk); #1;
      check("drain1_empty", OutValid, 1'b0);

      // Back-pressure: three back-to-back entries with the consumer stalled
      OutReady = 1'b0;
      send(4'b0001, 1'b1, 4'b0000, 4'b0001, 3'b000, 4'b0010);
      send(4'b0010, 1'b0, 4'b0000, 4'b0010, 3'b001, 4'b0010);
      check("full_inready", InReady, 1'b0);
      fork
         send(4'b0011, 1'b0, 4'b0000, 4'b0011, 3'b000, 4'b0000);
         begin
            repeat (3) @(posedge clk);
            #1;
            check("stall_inready", InReady, 1'b0);
            check("stall_head",    Result,  4'b0001);
            check("stall_flags",   Flags,   4'b0010);
            OutReady = 1'b1;
         end
      join
      repeat (2) @(posedge clk); #1;
      check("drain2_empty", OutValid, 1'b0);

      // ONE with simultaneous accept and pop: new entry becomes head
      OutReady = 1'b0;
      send(4'b0101, 1'b0, 4'b0010, 4'b0011, 3'b000, 4'b0000);
      OutReady = 1'b1;
      send(4'b1010, 1'b0, 4'b0101, 4'b0101, 3'b000, 4'b0101);
      check("one_ap_valid", OutValid, 1'b1);
      check("one_ap_ready", InReady,  1'b1);
      check("one_ap_head",  Result,   4'b1010);
      @(posedge clk); #1;

      // Clear sticky alone
      ClrSticky = 1'b1;
      @(posedge clk); #1;
      ClrSticky = 1'b0;
      check("clr_sticky", StickyV, 1'b0);

      // Reset while full with the producer still offering data
      OutReady = 1'b0;
      send(4'b0000, 1'b1, 4'b1000, 4'b1000, 3'b000, 4'b1011);
      send(4'b0001, 1'b0, 4'b0000, 4'b0001, 3'b000, 4'b0000);
      check("pre_rst_sticky", StickyV, 1'b1);
      check("pre_rst_full",   InReady, 1'b0);
      InValid = 1'b1; Sum = 4'b1111; Cout = 1'b0; AMod = 4'b0111; BMod = 4'b0111; Op = 3'b000;
      reset = 1'b1;
      sb.delete();
      @(posedge clk); #1;
      reset = 1'b0; InValid = 1'b0;
      check("mid_rst_outvalid", OutValid, 1'b0);
      check("mid_rst_inready",  InReady,  1'b1);
      check("mid_rst_sticky",   StickyV,  1'b0);
      check("mid_rst_result",   Result,   4'b0000);
      check("mid_rst_flags",    Flags,    4'b0000);

      // Clear together with an overflowing accept: set wins
      OutReady = 1'b1;
      ClrSticky = 1'b1;
      send(4'b1000, 1'b0, 4'b0111, 4'b0001, 3'b000, 4'b0101);
      check("clr_vs_set", StickyV, 1'b1);
      @(posedge clk); #1;
      ClrSticky = 1'b0;
      check("clr_after", StickyV, 1'b0);

      // Drain and confirm nothing is left outstanding
      for (int i = 0; i < 20 && sb.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      check("sb_empty",   sb.size(), 32'd0);
      check("end_empty",  OutValid,  1'b0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
